data_sram_bridge: RTL and testbench

- Sits between the combinational MEM stage and the data SRAM-like bus.
- Converts the MEM stage's single-cycle memory request (ce/we/addr/sel/data) into a bus transaction with an addr_ok/data_ok handshake.
- Stalls the pipeline until the transaction completes, then returns load data to the MEM stage's load-data input.
- Handles pipeline flush, including flush after the bus has already accepted a request.

---
 rtl/data_sram_bridge.sv | 118 +++++++++++
 tb/tb_data_sram_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Bridge between the MEM stage's single-cycle memory request and the
// SRAM-like data bus with addr_ok/data_ok handshake. It stalls the pipeline
// until the access completes and tolerates a flush at any point.
module data_sram_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_ce_i,
  input  logic                      mem_we_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   mem_sel_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  input  logic                      flush_i,
  output logic                      stall_req_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      rdata_valid_o,
  output logic                      data_req_o,
  output logic                      data_wr_o,
  output logic [DATA_WIDTH/8-1:0]   data_wstrb_o,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic                      data_addr_ok_i,
  input  logic                      data_data_ok_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Request attributes come straight from MEM; they stay stable while stalled.
  assign data_addr_o  = mem_addr_i;
  assign data_wdata_o = mem_wdata_i;
  assign data_wr_o    = mem_we_i;
  assign data_wstrb_o = mem_we_i ? mem_sel_i : STRB_WIDTH'(0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, bus request and stall generation.
  always_comb begin
    state_nxt   = state;
    data_req_o  = 1'b0;
    stall_req_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_ce_i && !flush_i) begin
          data_req_o  = 1'b1;
          stall_req_o = 1'b1;
          state_nxt   = data_addr_ok_i ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          state_nxt = S_IDLE;
        end else begin
          data_req_o  = 1'b1;
          stall_req_o = 1'b1;
          if (data_addr_ok_i) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_req_o = 1'b1;
        if (data_data_ok_i) begin
          state_nxt = flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          state_nxt = S_DROP;
        end
      end
      S_DONE: begin
        // Pipeline advances on this edge; never re-issue the same access.
        state_nxt = S_IDLE;
      end
      S_DROP: begin
        // Already-accepted access must drain before anything new is issued.
        stall_req_o = 1'b1;
        if (data_data_ok_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Load data capture and valid flag; valid coincides with the DONE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= (state_nxt == S_DONE);
      if (state == S_WAIT && data_data_ok_i && !flush_i && !mem_we_i) begin
        rdata_o <= data_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed, table-driven bench for data_sram_bridge.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, flush_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic        stall_req_o, rdata_valid_o, data_req_o, data_wr_o;
  logic [31:0] rdata_o, data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i, data_data_ok_i;

  int checks = 0;
  int failures = 0;
  int handshakes = 0;

  data_sram_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_wstrb_o(data_wstrb_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        fl, aok, dok;
    logic [31:0] rd;
    logic        e_stall, e_req;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic ce, logic we, logic [31:0] addr, logic [3:0] sel,
                             logic [31:0] wd, logic fl, logic aok, logic dok,
                             logic [31:0] rd, logic e_stall, logic e_req,
                             logic [3:0] e_wstrb, logic [31:0] e_rdata, logic e_valid);
    vec_t r;
    r.ce = ce; r.we = we; r.addr = addr; r.sel = sel; r.wd = wd;
    r.fl = fl; r.aok = aok; r.dok = dok; r.rd = rd;
    r.e_stall = e_stall; r.e_req = e_req; r.e_wstrb = e_wstrb;
    r.e_rdata = e_rdata; r.e_valid = e_valid;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd, input logic fl,
                       input logic aok, input logic dok, input logic [31:0] rd);
    mem_ce_i = ce; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel;
    mem_wdata_i = wd; flush_i = fl; data_addr_ok_i = aok;
    data_data_ok_i = dok; data_rdata_i = rd;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;

  initial begin
    string nm;
    bit    got;

    // Load word, bus accepts immediately, data_ok two cycles later.
    vecs.push_back(v(1,0,32'h1000_0004,4'hF,0,0,1,0,0,            1,1,0,0,0));
    vecs.push_back(v(1,0,32'h1000_0004,4'hF,0,0,0,0,0,            1,0,0,0,0));
    vecs.push_back(v(1,0,32'h1000_0004,4'hF,0,0,0,1,DB,           1,0,0,0,0));
    vecs.push_back(v(1,0,32'h1000_0004,4'hF,0,0,0,0,0,            0,0,0,DB,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Store byte with addr_ok delayed three cycles; rdata_o must not change.
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,0,0, 1,1,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,0,0, 1,1,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,0,0, 1,1,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,1,0,0, 1,1,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,0,0, 1,0,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,1,32'hFFFF_FFFF, 1,0,4'h1,DB,0));
    vecs.push_back(v(1,1,32'h1000_0003,4'h1,32'h5A5A5A5A,0,0,0,0, 0,0,4'h1,DB,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Flush while in REQ: request withdrawn the same cycle, no DONE.
    vecs.push_back(v(1,0,32'h2000_0000,4'hF,0,0,0,0,0,            1,1,0,DB,0));
    vecs.push_back(v(1,0,32'h2000_0000,4'hF,0,1,0,0,0,            0,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Flush coinciding with a new access in IDLE: nothing issued.
    vecs.push_back(v(1,0,32'h2000_0040,4'hF,0,1,0,0,0,            0,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Flush in WAIT, data_ok four cycles later; DROP ignores new ce.
    vecs.push_back(v(1,0,32'h3000_0000,4'hF,0,0,1,0,0,            1,1,0,DB,0));
    vecs.push_back(v(1,0,32'h3000_0000,4'hF,0,1,0,0,0,            1,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           1,0,0,DB,0));
    vecs.push_back(v(1,0,32'h3000_0100,4'hF,0,0,0,0,0,            1,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           1,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,32'h1234_5678,               1,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Flush together with data_ok in WAIT: straight back to IDLE, data dropped.
    vecs.push_back(v(1,0,32'h3000_0010,4'hF,0,0,1,0,0,            1,1,0,DB,0));
    vecs.push_back(v(1,0,32'h3000_0010,4'hF,0,1,0,1,32'h0BAD_F00D,1,0,0,DB,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,DB,0));
    // Two consecutive loads; second enters MEM right after DONE.
    vecs.push_back(v(1,0,32'h4000_0000,4'hF,0,0,1,0,0,            1,1,0,DB,0));
    vecs.push_back(v(1,0,32'h4000_0000,4'hF,0,0,0,1,R1,           1,0,0,DB,0));
    vecs.push_back(v(1,0,32'h4000_0000,4'hF,0,0,0,0,0,            0,0,0,R1,1));
    vecs.push_back(v(1,0,32'h4000_0004,4'hF,0,0,0,0,0,            1,1,0,R1,0));
    vecs.push_back(v(1,0,32'h4000_0004,4'hF,0,0,1,0,0,            1,1,0,R1,0));
    vecs.push_back(v(1,0,32'h4000_0004,4'hF,0,0,0,0,0,            1,0,0,R1,0));
    vecs.push_back(v(1,0,32'h4000_0004,4'hF,0,0,0,1,R2,           1,0,0,R1,0));
    vecs.push_back(v(1,0,32'h4000_0004,4'hF,0,0,0,0,0,            0,0,0,R2,1));
    // Stray data_ok in IDLE is ignored.
    vecs.push_back(v(0,0,0,0,0,0,0,1,32'h0000_0BAD,               0,0,0,R2,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,                           0,0,0,R2,0));

    // Reset state.
    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("reset_stall", 32'(stall_req_o), 0);
    chk("reset_req",   32'(data_req_o), 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_valid", 32'(rdata_valid_o), 0);
    next_cycle();

    // Table-driven cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wd,
            vecs[i].fl, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      #3;
      nm = $sformatf("v%0d", i);
      chk({nm, "_stall"}, 32'(stall_req_o),   32'(vecs[i].e_stall));
      chk({nm, "_req"},   32'(data_req_o),    32'(vecs[i].e_req));
      chk({nm, "_wstrb"}, 32'(data_wstrb_o),  32'(vecs[i].e_wstrb));
      chk({nm, "_rdata"}, rdata_o,            vecs[i].e_rdata);
      chk({nm, "_valid"}, 32'(rdata_valid_o), 32'(vecs[i].e_valid));
      if (vecs[i].ce) begin
        chk({nm, "_addr"},  data_addr_o,  vecs[i].addr);
        chk({nm, "_wdata"}, data_wdata_o, vecs[i].wd);
        chk({nm, "_wr"},    32'(data_wr_o), 32'(vecs[i].we));
      end
      if (data_req_o && data_addr_ok_i) handshakes++;
      next_cycle();
    end
    chk("handshake_count", 32'(handshakes), 32'd6);

    // Reset asserted while in WAIT.
    drive(1,0,32'h5000_0000,4'hF,0,0,1,0,0);
    #3;
    chk("rst_seq_req", 32'(data_req_o), 1);
    next_cycle();
    rst = 1'b1;
    drive(1,0,32'h5000_0000,4'hF,0,0,0,0,0);
    next_cycle();
    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    #3;
    chk("rst_mid_stall", 32'(stall_req_o), 0);
    chk("rst_mid_req",   32'(data_req_o), 0);
    chk("rst_mid_rdata", rdata_o, 0);
    chk("rst_mid_valid", 32'(rdata_valid_o), 0);
    next_cycle();

    // Following load completes normally (bounded wait for DONE).
    drive(1,0,32'h5000_0008,4'hF,0,0,1,0,0);
    #3;
    chk("post_rst_req", 32'(data_req_o), 1);
    next_cycle();
    drive(1,0,32'h5000_0008,4'hF,0,0,0,1,32'hCAFE_F00D);
    next_cycle();
    drive(1,0,32'h5000_0008,4'hF,0,0,0,0,0);
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      #3;
      if (rdata_valid_o) got = 1'b1;
      else next_cycle();
    end
    chk("post_rst_done_seen", 32'(got), 1);
    chk("post_rst_rdata", rdata_o, 32'hCAFE_F00D);
    chk("post_rst_stall", 32'(stall_req_o), 0);
    next_cycle();
    drive(0,0,0,0,0,0,0,0,0);
    #3;
    chk("post_rst_idle_valid", 32'(rdata_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
